// File: rtl/mem_sram_model.sv
`default_nettype none
// ============================================================================
// Module      : mem_sram_model
// Description : Single-port on-chip word array serving burst read/write
//               requests from the accelerator memory port, with read beats
//               returned under rd_ready flow control.
//               Optional beat statistics are enabled by defining MEM_SRAM_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_sram_model #(
    parameter int MEM_LEN_BITS  = 8,
    parameter int MEM_ADDR_BITS = 64,
    parameter int MEM_DATA_BITS = 64,
    parameter int DEPTH_LOG2    = 10
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     mem_req_valid,
    input  logic                     mem_req_opcode,
    input  logic [MEM_LEN_BITS-1:0]  mem_req_len,
    input  logic [MEM_ADDR_BITS-1:0] mem_req_addr,
    input  logic                     mem_wr_valid,
    input  logic [MEM_DATA_BITS-1:0] mem_wr_bits,
    output logic                     mem_rd_valid,
    output logic [MEM_DATA_BITS-1:0] mem_rd_bits,
    input  logic                     mem_rd_ready,
    output logic                     busy,
    output logic                     err_overrun,
    output logic [31:0]              rd_beat_count,
    output logic [31:0]              wr_beat_count
);

    localparam int                    C_WORD_SHIFT = $clog2(MEM_DATA_BITS / 8);
    localparam int                    C_DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [MEM_LEN_BITS:0] C_ONE_BEAT   = 1;
    localparam logic [DEPTH_LOG2-1:0] C_IDX_ONE    = 1;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WR       = 2'd1,
        S_RD_FETCH = 2'd2,
        S_RD_DATA  = 2'd3
    } state_t;

    state_t                   state_q;
    logic [DEPTH_LOG2-1:0]    idx_q;
    logic [MEM_LEN_BITS:0]    beats_left_q;
    logic [MEM_DATA_BITS-1:0] rd_bits_q;
    logic                     rd_valid_q;
    logic                     err_q;
    logic [MEM_DATA_BITS-1:0] mem_q [C_DEPTH];

    logic                     w_last_beat;
    logic                     w_wr_fire;
    logic [DEPTH_LOG2-1:0]    w_req_idx;
    logic                     unused_addr;

    assign w_last_beat = (beats_left_q == C_ONE_BEAT);
    assign w_wr_fire   = (state_q == S_WR) && mem_wr_valid && !reset;
    assign w_req_idx   = mem_req_addr[C_WORD_SHIFT +: DEPTH_LOG2];
    assign unused_addr = ^mem_req_addr;

    // Array contents survive reset; only the control path is cleared.
    always_ff @(posedge clock) begin
        if (w_wr_fire) begin
            mem_q[idx_q] <= mem_wr_bits;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            beats_left_q <= '0;
            rd_bits_q    <= '0;
            rd_valid_q   <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            if (mem_req_valid && (state_q != S_IDLE)) begin
                err_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (mem_req_valid) begin
                        idx_q        <= w_req_idx;
                        beats_left_q <= {1'b0, mem_req_len} + C_ONE_BEAT;
                        state_q      <= mem_req_opcode ? S_WR : S_RD_FETCH;
                    end
                end
                S_WR: begin
                    if (mem_wr_valid) begin
                        idx_q        <= idx_q + C_IDX_ONE;
                        beats_left_q <= beats_left_q - C_ONE_BEAT;
                        if (w_last_beat) begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                S_RD_FETCH: begin
                    rd_bits_q  <= mem_q[idx_q];
                    rd_valid_q <= 1'b1;
                    state_q    <= S_RD_DATA;
                end
                S_RD_DATA: begin
                    if (mem_rd_ready) begin
                        rd_valid_q   <= 1'b0;
                        beats_left_q <= beats_left_q - C_ONE_BEAT;
                        if (w_last_beat) begin
                            state_q <= S_IDLE;
                        end else begin
                            idx_q   <= idx_q + C_IDX_ONE;
                            state_q <= S_RD_FETCH;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign mem_rd_valid = rd_valid_q;
    assign mem_rd_bits  = rd_bits_q;
    assign busy         = (state_q != S_IDLE);
    assign err_overrun  = err_q;

`ifdef MEM_SRAM_STATS_EN
    logic        w_rd_fire;
    logic [31:0] rd_cnt_q;
    logic [31:0] wr_cnt_q;

    assign w_rd_fire = (state_q == S_RD_DATA) && mem_rd_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            if (w_rd_fire) begin
                rd_cnt_q <= rd_cnt_q + 32'd1;
            end
            if (w_wr_fire) begin
                wr_cnt_q <= wr_cnt_q + 32'd1;
            end
        end
    end

    assign rd_beat_count = rd_cnt_q;
    assign wr_beat_count = wr_cnt_q;
`else
    assign rd_beat_count = '0;
    assign wr_beat_count = '0;
`endif

endmodule
`default_nettype wire
